// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared constants and types for the Hamming decode path
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

endpackage

// File: rtl/hamming_rx_deserializer_sat_counter.sv
// rtl/hamming_rx_deserializer_sat_counter.sv - saturating increment counter
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hamming_rx_deserializer.sv
// rtl/hamming_rx_deserializer.sv - framed serial codeword receiver with one-entry delivery buffer
module hamming_rx_deserializer #(
  parameter int CODE_W    = hamming_pkg::CODE_W,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_serial_in,
  input  logic                 i_sink_busy,
  output logic [CODE_W-1:0]    o_code_out,
  output logic                 o_code_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic [ERR_CNT_W-1:0] o_frame_err_cnt,
  output logic [ERR_CNT_W-1:0] o_overrun_cnt
);

  import hamming_pkg::*;

  localparam int CNT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CODE_W - 1);

  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CODE_W-1:0] r_shift_reg;
  logic [CODE_W-1:0] r_buf_word;
  logic              r_buf_full;
  logic [CODE_W-1:0] r_code_out;
  logic              r_code_valid;
  logic              r_ferr_pend;
  logic              r_ovr_pend;
  logic              r_frame_err;
  logic              r_overrun;

  logic w_start;
  logic w_word_done;
  logic w_bad_stop;
  logic w_deliver;
  logic w_drop;

  assign w_start     = (r_state == IDLE) && (i_serial_in == START_BIT);
  assign w_word_done = (r_state == STOP) && (i_serial_in == STOP_BIT);
  assign w_bad_stop  = (r_state == STOP) && (i_serial_in != STOP_BIT);
  assign w_deliver   = r_buf_full && !i_sink_busy;
  assign w_drop      = w_word_done && r_buf_full && i_sink_busy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_serial_in == START_BIT) w_state_nxt = DATA;
      DATA:    if (r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
      STOP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bits enter at the top and walk down, so the first data bit ends in bit 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bit_cnt   <= '0;
      r_shift_reg <= '0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
    end else if (r_state == DATA) begin
      r_bit_cnt   <= r_bit_cnt + 1'b1;
      r_shift_reg <= {i_serial_in, r_shift_reg[CODE_W-1:1]};
    end
  end

  // Error pulses are delayed one stage so they line up with where the word's load pulse would be.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf_word   <= '0;
      r_buf_full   <= 1'b0;
      r_code_out   <= '0;
      r_code_valid <= 1'b0;
      r_ferr_pend  <= 1'b0;
      r_ovr_pend   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      if (w_deliver) begin
        r_code_out   <= r_buf_word;
        r_code_valid <= 1'b1;
      end
      if (w_word_done && (!r_buf_full || w_deliver)) begin
        r_buf_word <= r_shift_reg;
        r_buf_full <= 1'b1;
      end else if (w_deliver) begin
        r_buf_full <= 1'b0;
      end
      r_ferr_pend <= w_bad_stop;
      r_ovr_pend  <= w_drop;
      r_frame_err <= r_ferr_pend;
      r_overrun   <= r_ovr_pend;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_frame_err_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (r_ferr_pend),
    .o_count   (o_frame_err_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_overrun_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (r_ovr_pend),
    .o_count   (o_overrun_cnt)
  );

  assign o_code_out   = r_code_out;
  assign o_code_valid = r_code_valid;
  assign o_busy       = (r_state != IDLE);
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// tb/tb_hamming_rx_deserializer.sv - directed self-checking bench for hamming_rx_deserializer
module tb_hamming_rx_deserializer;

  logic       clk;
  logic       reset_n;
  logic       serial_in;
  logic       sink_busy;
  logic [6:0] code_out;
  logic       code_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [7:0] frame_err_cnt;
  logic [7:0] overrun_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nfe   = 0;
  int nov   = 0;
  int t0;
  logic [6:0] vq_code[$];
  int         vq_cyc[$];

  hamming_rx_deserializer #(.CODE_W(7), .ERR_CNT_W(8)) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_serial_in     (serial_in),
    .i_sink_busy     (sink_busy),
    .o_code_out      (code_out),
    .o_code_valid    (code_valid),
    .o_busy          (busy),
    .o_frame_err     (frame_err),
    .o_overrun       (overrun),
    .o_frame_err_cnt (frame_err_cnt),
    .o_overrun_cnt   (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the line bit, then sample 1ns after the edge and log pulses.
  task automatic step(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
    cyc++;
    if (code_valid) begin
      vq_code.push_back(code_out);
      vq_cyc.push_back(cyc);
    end
    if (frame_err) nfe++;
    if (overrun) nov++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic clr();
    nfe = 0;
    nov = 0;
    vq_code.delete();
    vq_cyc.delete();
  endtask

  task automatic send(input logic [6:0] w, input logic stop_b, input logic release_at_stop);
    step(1'b0);
    for (int i = 0; i < 7; i++) step(w[i]);
    if (release_at_stop) sink_busy = 1'b0;
    step(stop_b);
  endtask

  initial begin
    reset_n   = 1'b0;
    serial_in = 1'b1;
    sink_busy = 1'b0;
    idle(2);
    chk("rst_code_out", 32'(code_out), 32'h0);
    chk("rst_code_valid", 32'(code_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_fe_cnt", 32'(frame_err_cnt), 32'h0);
    chk("rst_ov_cnt", 32'(overrun_cnt), 32'h0);
    reset_n = 1'b1;
    idle(3);

    // Single frame 0x55: start edge is edge 1, load pulse appears after edge 10.
    clr();
    t0 = cyc + 1;
    step(1'b0);
    chk("single_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 7; i++) step(i[0] == 1'b0);
    step(1'b1);
    idle(3);
    chk("single_count", 32'(vq_code.size()), 32'd1);
    chk("single_code", 32'(vq_code[0]), 32'h55);
    chk("single_latency", 32'(vq_cyc[0] - t0), 32'd9);
    chk("single_nfe", 32'(nfe), 32'd0);
    chk("single_nov", 32'(nov), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'h0);
    chk("single_hold_code", 32'(code_out), 32'h55);

    clr();
    send(7'h0F, 1'b1, 1'b0);
    send(7'h70, 1'b1, 1'b0);
    idle(3);
    chk("b2b_count", 32'(vq_code.size()), 32'd2);
    chk("b2b_code0", 32'(vq_code[0]), 32'h0F);
    chk("b2b_code1", 32'(vq_code[1]), 32'h70);
    chk("b2b_spacing", 32'(vq_cyc[1] - vq_cyc[0]), 32'd9);

    clr();
    send(7'h2A, 1'b0, 1'b0);
    idle(3);
    chk("ferr_pulses", 32'(nfe), 32'd1);
    chk("ferr_cnt", 32'(frame_err_cnt), 32'd1);
    chk("ferr_no_valid", 32'(vq_code.size()), 32'd0);
    send(7'h11, 1'b1, 1'b0);
    idle(3);
    chk("ferr_next_count", 32'(vq_code.size()), 32'd1);
    chk("ferr_next_code", 32'(vq_code[0]), 32'h11);

    clr();
    sink_busy = 1'b1;
    send(7'h01, 1'b1, 1'b0);
    send(7'h02, 1'b1, 1'b0);
    send(7'h03, 1'b1, 1'b0);
    idle(5);
    chk("ovr_pulses", 32'(nov), 32'd2);
    chk("ovr_cnt", 32'(overrun_cnt), 32'd2);
    chk("ovr_held", 32'(vq_code.size()), 32'd0);
    sink_busy = 1'b0;
    idle(3);
    chk("ovr_release_count", 32'(vq_code.size()), 32'd1);
    chk("ovr_release_code", 32'(vq_code[0]), 32'h01);

    // 0x02 completes on the same edge the sink frees up.
    clr();
    sink_busy = 1'b1;
    send(7'h01, 1'b1, 1'b0);
    idle(2);
    send(7'h02, 1'b1, 1'b1);
    idle(3);
    chk("swap_count", 32'(vq_code.size()), 32'd2);
    chk("swap_code0", 32'(vq_code[0]), 32'h01);
    chk("swap_code1", 32'(vq_code[1]), 32'h02);
    chk("swap_gap", 32'(vq_cyc[1] - vq_cyc[0]), 32'd1);
    chk("swap_nov", 32'(nov), 32'd0);
    chk("swap_ov_cnt", 32'(overrun_cnt), 32'd2);

    clr();
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_code_out", 32'(code_out), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_fe_cnt", 32'(frame_err_cnt), 32'h0);
    chk("midrst_ov_cnt", 32'(overrun_cnt), 32'h0);
    chk("midrst_valid", 32'(code_valid), 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(12);
    chk("midrst_no_pulse", 32'(vq_code.size() + nfe + nov), 32'd0);

    clr();
    for (int i = 0; i < 300; i++) send(7'(i), 1'b0, 1'b0);
    idle(3);
    chk("sat_fe_cnt", 32'(frame_err_cnt), 32'd255);
    chk("sat_fe_pulses", 32'(nfe), 32'd300);
    chk("sat_no_valid", 32'(vq_code.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_rx_deserializer.md
# hamming_rx_deserializer

Serial-to-parallel front end for the Hamming decode path. It recovers framed 7-bit codewords from a one-bit-per-clock serial line, holds one completed codeword in a single-entry buffer, and delivers it to the decoder stage as a one-cycle load pulse. Delivery waits until the decoder's serializer is idle. The block sits directly upstream of the decoder: `code_out` drives the decoder's codeword input and `code_valid` drives its enable.

## Interface
- `CODE_W`, default 7: codeword width in bits.
- `ERR_CNT_W`, default 8: width of the saturating error counters.

- `clk`  in  1  rising-edge clock; one serial bit per cycle
- `reset_n`  in  1  asynchronous active-low reset
- `serial_in`  in  1  line data; idles high
- `sink_busy`  in  1  high while the downstream serializer is still shifting
- `code_out`  out  CODE_W  last delivered codeword; `code_out[0]` is the first data bit received
- `code_valid`  out  1  one-cycle load pulse qualifying `code_out`
- `busy`  out  1  high whenever the FSM is not in IDLE
- `frame_err`  out  1  one-cycle pulse on a bad stop bit
- `overrun`  out  1  one-cycle pulse when a completed word is dropped
- `frame_err_cnt`  out  ERR_CNT_W  saturating count of framing errors
- `overrun_cnt`  out  ERR_CNT_W  saturating count of overruns

## Operation
- **Frame format:** start bit `0`, then CODE_W data bits LSB-first, then stop bit `1`. There is no oversampling: each bit occupies exactly one clock.
- **FSM states:** IDLE, DATA, STOP.
  - IDLE: sampling `serial_in`=0 moves to DATA and clears `bit_cnt`.
  - DATA: each cycle shifts `serial_in` into `shift_reg[bit_cnt]` and increments `bit_cnt`. After bit CODE_W-1 the FSM moves to STOP.
  - STOP: if `serial_in`=1 the word is complete. If `serial_in`=0, `frame_err` pulses, `frame_err_cnt` increments, and the word is discarded. STOP always returns to IDLE.
- A low sampled in the STOP cycle is not reused as a start bit. A start bit is accepted in the first IDLE cycle after STOP, so frames can run back-to-back every CODE_W+2 cycles.
- **Buffer:** one entry, made of `buf_word` and `buf_full`.
  - Delivery edge: when `buf_full` && !`sink_busy`, drive `code_out`<=`buf_word`, `code_valid`<=1, and clear `buf_full`. On every other edge `code_valid`<=0.
  - Completion with `buf_full`=0: load `buf_word` and set `buf_full`.
  - Completion on an edge that is also a delivery edge: deliver the old word and load the new one on the same edge.
  - Completion with `buf_full`=1 and `sink_busy`=1: keep the buffered word, drop the new word, pulse `overrun`, and increment `overrun_cnt`.
- **Counters:** both saturate at all-ones and never wrap.
- **`code_out`:** holds its value between pulses.

## Timing
- **Reset values:** FSM=IDLE, `bit_cnt`=0, `shift_reg`=0, `buf_full`=0, `code_out`=0, `code_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0, both counters=0.
- **Reset during a frame:** the partial word is lost, and no pulse is emitted for it.
- **Latency:**
  - Let the stop bit be sampled at edge E. The buffer loads at E.
  - If `sink_busy` is low, `code_valid` goes high during the cycle after edge E+1.
  - From the start-bit edge to `code_valid` high is CODE_W+3 edges (10 for CODE_W=7).
- **Registered outputs:** `frame_err` and `overrun` are registered and asserted in the cycle after the STOP edge, the same cycle a `code_valid` for that word would appear.
- **`busy`:** high from the edge after the start bit is sampled through the STOP cycle.
- **`sink_busy`:** sampled only at delivery edges. It may stay high indefinitely; the buffer holds its word until it drops.

## Structure
- Shared package `hamming_pkg` holds:
  - `CODE_W`=7 and `DATA_W`=4 constants
  - `rx_state_t` enum {IDLE, DATA, STOP}
  - framing constants `START_BIT`=0 and `STOP_BIT`=1
- One sub-module is natural: `sat_counter`, a parameterised saturating increment counter with async active-low reset. Instantiate it twice, once for framing errors and once for overruns.
- The FSM, shift register and buffer stay in the top module.

## Test plan
- **Single frame:** idle high, then bits 0,1,0,1,0,1,0,1,1 (start, data 7'h55 LSB-first, stop), `sink_busy`=0. Required: one `code_valid` pulse with `code_out`=7'h55, 10 edges after the start bit. No `frame_err`, no `overrun`.
- **Back-to-back frames:** 7'h0F then 7'h70 with no idle gap, `sink_busy`=0. Required: two `code_valid` pulses exactly 9 cycles apart with values 7'h0F then 7'h70.
- **Framing error:** frame 7'h2A with stop bit 0. Required: `frame_err` pulses once, `frame_err_cnt`=1, no `code_valid`. A following good frame 7'h11 is delivered normally.
- **Backpressure and overrun:** hold `sink_busy`=1 and send 7'h01, 7'h02, 7'h03. Required:
  - `overrun` pulses for 7'h02 and for 7'h03, `overrun_cnt`=2.
  - After `sink_busy` drops, exactly one `code_valid` with 7'h01.
- **Swap on free:** buffer holds 7'h01 with `sink_busy`=1. Release `sink_busy` on the same edge that 7'h02 completes. Required: 7'h01 is delivered, no `overrun`, and 7'h02 is delivered on the next edge.
- **Reset and saturation:**
  - Assert `reset_n` low mid-DATA. Required: all outputs read zero immediately, and the aborted frame produces no pulse.
  - Force 300 framing errors with ERR_CNT_W=8. Required: `frame_err_cnt` sticks at 255.
